// File: rtl/icache_tag_req_sched.sv
// Shares the icache tag pipeline among fetch, snoop and prefetch through one registered slot.
// Define ICACHE_TAG_SCHED_STARVE_EN to add snoop/prefetch wait counters and starvation promotion.

package toy_pack;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  id;
  } pc_req_t;
endpackage

module icache_tag_req_sched
  import toy_pack::*;
#(
  parameter int unsigned STARVE_MAX = 7,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       upstream_rxreq_vld,
  output logic       upstream_rxreq_rdy,
  input  pc_req_t    upstream_rxreq_pld,

  input  logic       downstream_rxsnp_vld,
  output logic       downstream_rxsnp_rdy,
  input  pc_req_t    downstream_rxsnp_pld,

  input  logic       prefetch_req_vld,
  output logic       prefetch_req_rdy,
  input  pc_req_t    prefetch_req_pld,

  output logic       tag_req_vld,
  input  logic       tagram_req_rdy,
  input  logic       mshr_tag_req_rdy,
  output pc_req_t    tag_req_pld,
  output logic [1:0] tag_req_src
);

  typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;
  typedef enum logic [1:0] {SrcUp = 2'd0, SrcSnp = 2'd1, SrcPf = 2'd2} src_e;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("icache_tag_req_sched: STARVE_MAX must be within 1..255");
  end
  if (CNT_W != $clog2(STARVE_MAX + 1)) begin : g_bad_cnt_w
    $error("icache_tag_req_sched: CNT_W is derived and must not be overridden");
  end

  slot_state_e state_q, state_d;
  pc_req_t     pld_q;
  src_e        src_q;

  logic    out_rdy, drain, slot_free, can_grant;
  logic    gnt_up, gnt_snp, gnt_pf, gnt_any;
  logic    snp_starved, pf_starved;
  pc_req_t gnt_pld;
  src_e    gnt_src;

  assign out_rdy   = tagram_req_rdy & mshr_tag_req_rdy;
  assign drain     = (state_q == StFull) & out_rdy;
  assign slot_free = (state_q == StEmpty) | drain;
  // Holding grants off during reset keeps all rdys low while rst_n is asserted.
  assign can_grant = slot_free & rst_n;

`ifdef ICACHE_TAG_SCHED_STARVE_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] snp_cnt_q, snp_cnt_d;
  logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;

  function automatic logic [CNT_W-1:0] next_cnt(input logic             vld,
                                                input logic             won,
                                                input logic             any,
                                                input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (!vld || won) begin
      nxt = '0;
    end else if (any && (cnt < CntMax)) begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  assign snp_starved = (snp_cnt_q == CntMax);
  assign pf_starved  = (pf_cnt_q == CntMax);

  always_comb begin
    snp_cnt_d = next_cnt(downstream_rxsnp_vld, gnt_snp, gnt_any, snp_cnt_q);
    pf_cnt_d  = next_cnt(prefetch_req_vld, gnt_pf, gnt_any, pf_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snp_cnt_q <= '0;
      pf_cnt_q  <= '0;
    end else begin
      snp_cnt_q <= snp_cnt_d;
      pf_cnt_q  <= pf_cnt_d;
    end
  end
`else
  assign snp_starved = 1'b0;
  assign pf_starved  = 1'b0;
`endif

  // Starved snoop, then starved prefetch, then base order upstream > snoop > prefetch.
  always_comb begin
    gnt_up  = 1'b0;
    gnt_snp = 1'b0;
    gnt_pf  = 1'b0;
    if (can_grant) begin
      if (downstream_rxsnp_vld && snp_starved) begin
        gnt_snp = 1'b1;
      end else if (prefetch_req_vld && pf_starved) begin
        gnt_pf = 1'b1;
      end else if (upstream_rxreq_vld) begin
        gnt_up = 1'b1;
      end else if (downstream_rxsnp_vld) begin
        gnt_snp = 1'b1;
      end else if (prefetch_req_vld) begin
        gnt_pf = 1'b1;
      end
    end
  end

  assign gnt_any = gnt_up | gnt_snp | gnt_pf;

  always_comb begin
    gnt_pld = upstream_rxreq_pld;
    gnt_src = SrcUp;
    unique case (1'b1)
      gnt_snp: begin
        gnt_pld = downstream_rxsnp_pld;
        gnt_src = SrcSnp;
      end
      gnt_pf: begin
        gnt_pld = prefetch_req_pld;
        gnt_src = SrcPf;
      end
      default: ;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (gnt_any)          state_d = StFull;
      StFull:  if (drain && !gnt_any) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Payload and source only move on a grant; they hold across a drain-only cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pld_q <= '0;
      src_q <= SrcUp;
    end else if (gnt_any) begin
      pld_q <= gnt_pld;
      src_q <= gnt_src;
    end
  end

  // Outputs.
  always_comb begin
    tag_req_vld          = (state_q == StFull);
    tag_req_pld          = pld_q;
    tag_req_src          = src_q;
    upstream_rxreq_rdy   = gnt_up;
    downstream_rxsnp_rdy = gnt_snp;
    prefetch_req_rdy     = gnt_pf;
  end

endmodule
